// File: rtl/grant_mux_pkg.sv
// rtl/grant_mux_pkg.sv - shared state type and width helper for grant_mux
package grant_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } grant_mux_state_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/grant_enc.sv
// rtl/grant_enc.sv - grant vector to lowest-set-bit index, purely combinational
module grant_enc
  import grant_mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         grant,
  output logic [idx_w(N)-1:0]  idx,
  output logic                 any
);

  localparam int IW = idx_w(N);

  // Scan from the top so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (grant[i]) idx = IW'(i);
    end
  end

  assign any = |grant;

endmodule

// File: rtl/grant_mux.sv
// rtl/grant_mux.sv - locks onto the granted source and forwards its packet; GRANT_MUX_TIMEOUT_EN adds an idle abort
module grant_mux
  import grant_mux_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         grant,
  input  logic [N-1:0]         src_valid,
  input  logic [N*W-1:0]       src_data,
  input  logic [N-1:0]         src_last,
  output logic [N-1:0]         src_ready,
  output logic                 dst_valid,
  output logic [W-1:0]         dst_data,
  output logic                 dst_last,
  input  logic                 dst_ready,
  output logic                 busy,
  output logic [idx_w(N)-1:0]  owner,
  output logic                 done
`ifdef GRANT_MUX_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int IW = idx_w(N);

  if (N < 2 || TIMEOUT < 2) begin : g_bad_params
    $error("grant_mux: N and TIMEOUT must both be >= 2");
  end

  grant_mux_state_e state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             dst_valid_q, dst_valid_d;
  logic [W-1:0]     dst_data_q, dst_data_d;
  logic             dst_last_q, dst_last_d;
  logic             done_q, done_d;
  logic [IW-1:0]    enc_idx;
  logic             enc_any;
  logic             out_free;
  logic             accept;

`ifdef GRANT_MUX_TIMEOUT_EN
  localparam int CW = idx_w(TIMEOUT);
  logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             aborted_q, aborted_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  grant_enc #(.N(N)) u_grant_enc (
    .grant (grant),
    .idx   (enc_idx),
    .any   (enc_any)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
      dst_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef GRANT_MUX_TIMEOUT_EN
      idle_cnt_q    <= '0;
      aborted_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      dst_valid_q <= dst_valid_d;
      dst_data_q  <= dst_data_d;
      dst_last_q  <= dst_last_d;
      done_q      <= done_d;
`ifdef GRANT_MUX_TIMEOUT_EN
      idle_cnt_q    <= idle_cnt_d;
      aborted_q     <= aborted_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    dst_valid_d = dst_valid_q;
    dst_data_d  = dst_data_q;
    dst_last_d  = dst_last_q;
    done_d      = 1'b0;
`ifdef GRANT_MUX_TIMEOUT_EN
    idle_cnt_d    = idle_cnt_q;
    aborted_d     = aborted_q;
    timeout_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          owner_d = enc_idx;
          state_d = XFER;
        end
`ifdef GRANT_MUX_TIMEOUT_EN
        idle_cnt_d = '0;
        aborted_d  = 1'b0;
`endif
      end
      XFER: begin
        if (accept) begin
          dst_valid_d = 1'b1;
          dst_data_d  = src_data[int'(owner_q)*W +: W];
          dst_last_d  = src_last[owner_q];
          if (src_last[owner_q]) state_d = FLUSH;
        end else if (dst_ready) begin
          dst_valid_d = 1'b0;
        end
`ifdef GRANT_MUX_TIMEOUT_EN
        // A stalled source ends the packet with a zero terminator, or tags the held beat as last.
        if (accept) begin
          idle_cnt_d = '0;
        end else if (!src_valid[owner_q]) begin
          if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
            state_d   = FLUSH;
            aborted_d = 1'b1;
            if (out_free) begin
              dst_valid_d = 1'b1;
              dst_last_d  = 1'b1;
              dst_data_d  = '0;
            end else begin
              dst_last_d = 1'b1;
            end
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
`endif
      end
      FLUSH: begin
        if (dst_valid_q && dst_ready && dst_last_q) begin
          dst_valid_d = 1'b0;
          state_d     = IDLE;
          done_d      = 1'b1;
`ifdef GRANT_MUX_TIMEOUT_EN
          timeout_err_d = aborted_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_free  = !dst_valid_q || dst_ready;
    src_ready = '0;
    if (state_q == XFER) src_ready[owner_q] = out_free;
  end

  assign accept    = src_valid[owner_q] && src_ready[owner_q];
  assign dst_valid = dst_valid_q;
  assign dst_data  = dst_data_q;
  assign dst_last  = dst_last_q;
  assign busy      = (state_q == XFER) || (state_q == FLUSH);
  assign owner     = owner_q;
  assign done      = done_q;
`ifdef GRANT_MUX_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_grant_mux.sv
// tb/tb_grant_mux.sv - randomized self-checking bench for grant_mux against a packet-level model
module tb_grant_mux;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int IW      = $clog2(N);
  localparam int TIMEOUT = 4;
  localparam int BUDGET  = 300;
`ifdef GRANT_MUX_TIMEOUT_EN
  localparam int VLO = 100;
`else
  localparam int VLO = 40;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   grant, src_valid, src_last, src_ready;
  logic [N*W-1:0] src_data;
  logic           dst_valid, dst_last, dst_ready, busy, done;
  logic [W-1:0]   dst_data;
  logic [IW-1:0]  owner;
`ifdef GRANT_MUX_TIMEOUT_EN
  logic           timeout_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] pkt[$];
  logic [W-1:0] obs_data[$];
  logic         obs_last[$];
  int r_viol, r_done, r_done_cyc, r_ready_lat, r_out_first, r_out_last;

  always #5 clk = ~clk;

  grant_mux #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .grant     (grant),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_last  (dst_last),
    .dst_ready (dst_ready),
    .busy      (busy),
    .owner     (owner),
    .done      (done)
`ifdef GRANT_MUX_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  function automatic int lowest(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Drives pkt[] from source src as a well-behaved stream, records the output stream and protocol violations.
  task automatic run_pkt(input logic [N-1:0] g, input int src, input bit pre_granted,
                         input logic [N-1:0] next_grant, input int vpct, input int rpct);
    int bi, nb;
    bit acc, done_seen;
    logic [N-1:0] mine;
    nb = pkt.size();
    obs_data.delete();
    obs_last.delete();
    r_viol = 0; r_done = 0; r_done_cyc = -1; r_ready_lat = -1; r_out_first = -1; r_out_last = -1;
    bi = 0; acc = 1'b0; done_seen = 1'b0;
    mine = '0;
    mine[src] = 1'b1;
    src_valid = '0;
    if (!pre_granted) grant = g;
    for (int cyc = 0; cyc < BUDGET && !done_seen; cyc++) begin
      for (int j = 0; j < N; j++) begin
        if (j != src) begin
          src_valid[j] = 1'($urandom_range(1));
          src_data[j*W +: W] = $urandom();
          src_last[j] = 1'($urandom_range(1));
        end
      end
      if (!(src_valid[src] && !acc))
        src_valid[src] = (bi < nb) && ($urandom_range(99) < vpct);
      if (bi < nb) src_data[src*W +: W] = pkt[bi];
      src_last[src] = (bi == nb - 1);
      dst_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      acc = src_valid[src] && src_ready[src];
      if (src_ready[src] && r_ready_lat < 0) r_ready_lat = cyc;
      if ((src_ready & ~mine) != '0) r_viol++;
      if (dst_valid && !dst_ready && src_ready != '0) r_viol++;
      if (busy && owner !== IW'(src)) r_viol++;
      if (acc) bi++;
      if (dst_valid && dst_ready) begin
        obs_data.push_back(dst_data);
        obs_last.push_back(dst_last);
        if (r_out_first < 0) r_out_first = cyc;
        r_out_last = cyc;
      end
      if (done) begin
        r_done++;
        r_done_cyc = cyc;
        done_seen = 1'b1;
        grant = next_grant;
      end
      @(posedge clk);
      #1;
      if (!done_seen) grant = N'($urandom());
    end
    src_valid = '0;
    src_last  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    grant = 4'b0010;
    dst_ready = 1'b1;
    repeat (3) begin
      src_valid = N'($urandom());
      @(negedge clk);
      vectors++;
      if ({dst_valid, dst_last, done, busy} !== 4'b0 || dst_data !== '0) begin
        miscompares++;
        $display("FAIL reset_dst: valid=%b last=%b done=%b busy=%b data=%h, required all zero",
                 dst_valid, dst_last, done, busy, dst_data);
      end
      vectors++;
      if (src_ready !== '0 || owner !== '0) begin
        miscompares++;
        $display("FAIL reset_ctl: src_ready=%b owner=%0d, required 0/0", src_ready, owner);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    grant = '0;
    src_valid = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0/0", busy, done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    pkt = '{32'hA1, 32'hA2, 32'hA3};
    run_pkt(4'b0100, 2, 1'b0, '0, 100, 100);
    vectors++;
    if (r_ready_lat !== 1) begin
      miscompares++;
      $display("FAIL basic_ready_latency: got %0d cycles, required 1", r_ready_lat);
    end
    vectors++;
    if (obs_data.size() != 3) begin
      miscompares++;
      $display("FAIL basic_beat_count: got %0d, required 3", obs_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs_data[i] !== pkt[i] || obs_last[i] !== (i == 2)) begin
          miscompares++;
          $display("FAIL basic_beat%0d: got %h/%b, required %h/%b", i, obs_data[i], obs_last[i], pkt[i], i == 2);
        end
      end
    end
    vectors++;
    if (r_out_last - r_out_first !== 2 || r_done !== 1 || r_done_cyc !== 5) begin
      miscompares++;
      $display("FAIL basic_timing: span=%0d done=%0d done_cyc=%0d, required 2/1/5",
               r_out_last - r_out_first, r_done, r_done_cyc);
    end
    vectors++;
    if (r_viol !== 0) begin
      miscompares++;
      $display("FAIL basic_protocol: got %0d violations, required 0", r_viol);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || owner !== IW'(2)) begin
      miscompares++;
      $display("FAIL basic_after: done=%b busy=%b owner=%0d, required 0/0/2", done, busy, owner);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) begin
      pkt = '{32'hA1, 32'hA2, 32'hA3};
      run_pkt(4'b0100, 2, 1'b0, '0, $urandom_range(VLO, 100), 50);
      vectors++;
      if (r_done !== 1 || r_viol !== 0 || obs_data.size() != 3) begin
        miscompares++;
        $display("FAIL bp%0d_summary: done=%0d viol=%0d beats=%0d, required 1/0/3", k, r_done, r_viol, obs_data.size());
      end else begin
        for (int i = 0; i < 3; i++) begin
          vectors++;
          if (obs_data[i] !== pkt[i] || obs_last[i] !== (i == 2)) begin
            miscompares++;
            $display("FAIL bp%0d_beat%0d: got %h/%b, required %h/%b", k, i, obs_data[i], obs_last[i], pkt[i], i == 2);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    pkt = '{32'hA1, 32'hA2, 32'hA3};
    run_pkt(4'b0100, 2, 1'b0, 4'b1000, 100, 100);
    vectors++;
    if (r_done !== 1 || r_viol !== 0) begin
      miscompares++;
      $display("FAIL b2b_first: done=%0d viol=%0d, required 1/0", r_done, r_viol);
    end
    pkt = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
    run_pkt('0, 3, 1'b1, '0, $urandom_range(VLO, 100), $urandom_range(50, 100));
    vectors++;
    if (r_ready_lat !== 0) begin
      miscompares++;
      $display("FAIL b2b_zero_gap: first src_ready at cycle %0d, required 0", r_ready_lat);
    end
    vectors++;
    if (r_done !== 1 || r_viol !== 0 || obs_data.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_second: done=%0d viol=%0d beats=%0d, required 1/0/4", r_done, r_viol, obs_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (obs_data[i] !== pkt[i] || obs_last[i] !== (i == 3)) begin
          miscompares++;
          $display("FAIL b2b_beat%0d: got %h/%b, required %h/%b", i, obs_data[i], obs_last[i], pkt[i], i == 3);
        end
      end
    end
  endtask

  task automatic test_multi_hot_single();
    pkt = '{32'h55};
    run_pkt(4'b1010, 1, 1'b0, '0, 100, 100);
    vectors++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'h55 || obs_last[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_beat: got %0d beats first=%h, required 1 beat 55 with last", obs_data.size(),
               (obs_data.size() > 0) ? obs_data[0] : '0);
    end
    vectors++;
    if (r_done !== 1 || r_done_cyc !== 3 || r_viol !== 0) begin
      miscompares++;
      $display("FAIL single_timing: done=%0d done_cyc=%0d viol=%0d, required 1/3/0", r_done, r_done_cyc, r_viol);
    end
    @(negedge clk);
    vectors++;
    if (owner !== IW'(1) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_hot_owner: owner=%0d busy=%b, required 1/0", owner, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    int src, nb;
    for (int k = 0; k < 20; k++) begin
      g = N'($urandom_range(1, (1 << N) - 1));
      src = lowest(g);
      nb = $urandom_range(1, 6);
      pkt.delete();
      repeat (nb) pkt.push_back($urandom());
      run_pkt(g, src, 1'b0, '0, $urandom_range(VLO, 100), $urandom_range(30, 100));
      vectors++;
      if (r_done !== 1 || r_viol !== 0 || obs_data.size() != nb) begin
        miscompares++;
        $display("FAIL rand%0d_summary: grant=%b done=%0d viol=%0d beats=%0d, required 1/0/%0d",
                 k, g, r_done, r_viol, obs_data.size(), nb);
      end else begin
        for (int i = 0; i < nb; i++) begin
          vectors++;
          if (obs_data[i] !== pkt[i] || obs_last[i] !== (i == nb - 1)) begin
            miscompares++;
            $display("FAIL rand%0d_beat%0d: got %h/%b, required %h/%b", k, i, obs_data[i], obs_last[i],
                     pkt[i], i == nb - 1);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) begin
      grant = (c == 0) ? 4'b0001 : 4'b0000;
      reset = (c == 2) ? 1'b0 : 1'b1;
      src_valid = (c == 1 || c == 2) ? 4'b0001 : 4'b0000;
      src_data[W-1:0] = (c == 1) ? 32'h11 : 32'h22;
      src_last = '0;
      dst_ready = 1'b1;
      @(negedge clk);
      if (c == 1) begin
        vectors++;
        if (src_ready !== 4'b0001) begin
          miscompares++;
          $display("FAIL rstmid_ready: src_ready=%b, required 0001", src_ready);
        end
      end
      if (c == 2) begin
        vectors++;
        if (dst_valid !== 1'b1 || dst_data !== 32'h11) begin
          miscompares++;
          $display("FAIL rstmid_beat1: valid=%b data=%h, required 1/11", dst_valid, dst_data);
        end
      end
      if (c == 3) begin
        vectors++;
        if ({busy, dst_valid, done} !== 3'b0 || src_ready !== '0) begin
          miscompares++;
          $display("FAIL rstmid_idle: busy=%b valid=%b done=%b src_ready=%b, required all 0",
                   busy, dst_valid, done, src_ready);
        end
      end
      if (c == 4) begin
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL rstmid_nodone: done=%b busy=%b, required 0/0", done, busy);
        end
      end
      @(posedge clk);
      #1;
    end
    src_valid = '0;
  endtask

`ifdef GRANT_MUX_TIMEOUT_EN
  task automatic test_timeout();
    // Empty output register: zero terminator after four idle cycles.
    for (int c = 0; c < 8; c++) begin
      grant = (c == 0) ? 4'b0001 : 4'b0000;
      src_valid = '0;
      dst_ready = 1'b1;
      @(negedge clk);
      if (c == 4) begin
        vectors++;
        if (dst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL to_early: dst_valid=%b at idle cycle 4, required 0", dst_valid);
        end
      end
      if (c == 5) begin
        vectors++;
        if ({dst_valid, dst_last} !== 2'b11 || dst_data !== '0) begin
          miscompares++;
          $display("FAIL to_term: valid=%b last=%b data=%h, required 1/1/0", dst_valid, dst_last, dst_data);
        end
      end
      if (c == 6 || c == 7) begin
        vectors++;
        if ({done, timeout_err} !== ((c == 6) ? 2'b11 : 2'b00)) begin
          miscompares++;
          $display("FAIL to_pulse%0d: done=%b timeout_err=%b, required %0d", c, done, timeout_err, c == 6);
        end
      end
      @(posedge clk);
      #1;
    end
    // Held beat under backpressure gets tagged as last instead.
    for (int c = 0; c < 9; c++) begin
      grant = (c == 0) ? 4'b0001 : 4'b0000;
      src_valid = (c == 1) ? 4'b0001 : 4'b0000;
      src_data[W-1:0] = 32'hBEEF;
      src_last = '0;
      dst_ready = (c <= 1 || c >= 6);
      @(negedge clk);
      if (c == 5) begin
        vectors++;
        if ({dst_valid, dst_last} !== 2'b10) begin
          miscompares++;
          $display("FAIL to_pending: valid=%b last=%b, required 1/0", dst_valid, dst_last);
        end
      end
      if (c == 6) begin
        vectors++;
        if ({dst_valid, dst_last} !== 2'b11 || dst_data !== 32'hBEEF) begin
          miscompares++;
          $display("FAIL to_forced_last: valid=%b last=%b data=%h, required 1/1/beef", dst_valid, dst_last, dst_data);
        end
      end
      if (c == 7) begin
        vectors++;
        if ({done, timeout_err} !== 2'b11) begin
          miscompares++;
          $display("FAIL to_pending_pulse: done=%b timeout_err=%b, required 1/1", done, timeout_err);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    grant     = '0;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    dst_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_multi_hot_single();
    test_random();
    test_reset_mid();
`ifdef GRANT_MUX_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grant_mux.md
Name: grant_mux

Overview:
- Downstream consumer of the round-robin arbiter's one-hot `grant` vector.
- Locks onto the granted source, muxes that source's multi-beat packet onto one shared output channel with a registered output stage, and releases the lock after the last beat leaves.
- Pulses `done` so the arbitration loop can advance.

Parameters:
- N, 4, number of sources; must match the arbiter's N; N ≥ 2.
- W, 32, data width per beat.
- TIMEOUT, 16, idle-cycle limit; used only when GRANT_MUX_TIMEOUT_EN is defined; ≥ 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- grant  in  N  one-hot grant from the arbiter; sampled only in IDLE.
- src_valid  in  N  per-source beat valid.
- src_data  in  N*W  packed source data; source i occupies bits [i*W +: W].
- src_last  in  N  per-source last-beat flag.
- src_ready  out  N  per-source ready; at most one bit high.
- dst_valid  out  1  output beat valid (registered).
- dst_data  out  W  output beat data (registered).
- dst_last  out  1  output last flag (registered).
- dst_ready  in  1  downstream ready.
- busy  out  1  high in XFER or FLUSH.
- owner  out  $clog2(N)  index of the locked source; holds its last value when not busy.
- done  out  1  one-cycle pulse when a packet fully completes.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, owner=0.
  - dst_valid=0, dst_data=0, dst_last=0, done=0, src_ready=0.
  - Applies from any state; a packet in flight is dropped, with no done pulse.
- FSM states: IDLE, XFER, FLUSH.
- IDLE:
  - src_ready=0.
  - If grant≠0: capture owner=index of the lowest set bit, go to XFER next cycle.
  - Otherwise stay in IDLE.
- XFER:
  - src_ready[owner] = (!dst_valid || dst_ready). All other src_ready bits are 0.
  - Source beat accepted when src_valid[owner] && src_ready[owner]. The output register loads src_data/src_last of owner and sets dst_valid=1.
  - If dst_ready is high and no new beat is accepted, dst_valid clears.
  - Accepted beat with src_last=1 → go to FLUSH; src_ready drops next cycle.
- FLUSH:
  - src_ready=0.
  - When dst_valid && dst_ready && dst_last → dst_valid=0, state=IDLE, done=1 for exactly one cycle.
- done:
  - Asserts in the first IDLE cycle after a completed packet.
  - grant is also sampled in that same cycle, so back-to-back packets are allowed.
- Latency and throughput:
  - grant to first src_ready: 1 cycle.
  - Source accept to dst_valid: 1 cycle.
  - Full throughput: 1 beat/cycle when dst_ready is held high.
- grant ignored in XFER and FLUSH, even if it changes or goes to zero; the lock persists until done.
- Multi-hot grant: lowest index wins; no error output.
- Single-beat packet (src_last on the first beat): the path is XFER → FLUSH → IDLE.
- dst_data holds its value while dst_valid=0 (no forced zeroing).
- No combinational path from grant to any output.

Optional Feature:
- Macro: GRANT_MUX_TIMEOUT_EN.
- Defined:
  - A counter runs in XFER. It clears on any accepted beat and increments on every cycle with src_valid[owner]==0.
  - When the counter reaches TIMEOUT-1, the transfer aborts: state=FLUSH with a synthetic terminator.
  - If the output register is empty, load dst_valid=1, dst_last=1, dst_data=0.
  - Otherwise force dst_last=1 on the pending beat.
  - done pulses as for a normal completion.
  - Output `timeout_err` (1 bit) pulses for one cycle, simultaneously with done.
- Undefined:
  - No counter and no timeout_err port.
  - XFER waits indefinitely.

Decomposition:
- Package grant_mux_pkg:
  - state enum `grant_mux_state_e` {IDLE, XFER, FLUSH}, 2 bits.
  - Localparam function `idx_w(n)` returning `$clog2(n)`.
- Sub-module grant_enc: parameter N; one-hot to lowest-index encoder, purely combinational. Outputs `idx` and `any`. Instantiated once for grant capture.

Test Plan:
1. Reset: drive reset=0 for 3 cycles with grant=4'b0010 → all outputs 0, state IDLE, no done.
2. Basic packet: grant=4'b0100, src 2 sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3), dst_ready=1 → src_ready[2] rises 1 cycle after grant; dst sees 0xA1..0xA3 on consecutive cycles with dst_last on 0xA3; done pulses once; owner=2.
3. Backpressure: same packet with dst_ready toggling 1,0,0,1,… → no beat lost or duplicated; src_ready[2]=0 whenever dst_valid && !dst_ready.
4. Back-to-back: after packet 2, grant=4'b1000 held during the done cycle → new lock to owner=3 with zero idle cycles; grant changes during XFER are ignored.
5. Multi-hot and single-beat: grant=4'b1010, src 1 sends one beat 0x55 with last → owner=1, path XFER→FLUSH→IDLE, done after dst handshake.
6. Reset mid-packet, plus GRANT_MUX_TIMEOUT_EN with TIMEOUT=4:
   - Reset asserted after beat 1 → no done; IDLE on the next cycle.
   - With timeout enabled, src_valid held low 4 cycles in XFER → terminator beat dst_last=1, dst_data=0; done and timeout_err pulse together.
